// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing one bank of negative-edge J-K flip-flops between requesters A and B.
// Optional bank readback with a sticky Mismatch flag is enabled by defining JK_ARB_READBACK_EN.
module jk_bank_arbiter #(
    parameter int unsigned BLOCKS       = 3,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int          DELAY_RISE   = 0,
    parameter int          DELAY_FALL   = 0
) (
    input  logic              Clk,
    input  logic              Clear_bar,
    input  logic              Req_A,
    input  logic              Req_B,
    input  logic [1:0]        Op_A,
    input  logic [1:0]        Op_B,
    input  logic [BLOCKS-1:0] Data_A,
    input  logic [BLOCKS-1:0] Data_B,
    input  logic [BLOCKS-1:0] Mask_A,
    input  logic [BLOCKS-1:0] Mask_B,
    output logic              Grant_A,
    output logic              Grant_B,
    output logic              Ack_A,
    output logic              Ack_B,
    output logic              Busy,
    output logic [BLOCKS-1:0] J,
    output logic [BLOCKS-1:0] K,
    output logic              Strobe_bar
`ifdef JK_ARB_READBACK_EN
    ,
    input  logic [BLOCKS-1:0] Q,
    output logic              Mismatch
`endif
);

    localparam int unsigned CNT_W = 4;

    // Output delays are a netlist/timing attribute; the RTL itself is zero-delay.
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_param_check
        $error("jk_bank_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_PULSE   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               prio_a, prio_a_n;
    logic               take_a;
    logic               grant_a_n, grant_b_n, ack_a_n, ack_b_n, busy_n, strobe_n;
    logic [BLOCKS-1:0]  j_n, k_n;

    function automatic logic [BLOCKS-1:0] calc_j(input logic [1:0] op,
                                                 input logic [BLOCKS-1:0] d,
                                                 input logic [BLOCKS-1:0] m);
        case (op)
            2'b01:   calc_j = d & m;
            2'b10:   calc_j = m;
            default: calc_j = '0;
        endcase
    endfunction

    function automatic logic [BLOCKS-1:0] calc_k(input logic [1:0] op,
                                                 input logic [BLOCKS-1:0] d,
                                                 input logic [BLOCKS-1:0] m);
        case (op)
            2'b01:         calc_k = ~d & m;
            2'b10, 2'b11:  calc_k = m;
            default:       calc_k = '0;
        endcase
    endfunction

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        prio_a_n  = prio_a;
        take_a    = 1'b0;
        grant_a_n = Grant_A;
        grant_b_n = Grant_B;
        ack_a_n   = 1'b0;
        ack_b_n   = 1'b0;
        busy_n    = Busy;
        strobe_n  = 1'b1;
        j_n       = J;
        k_n       = K;
        case (state)
            ST_IDLE: begin
                if (Req_A || Req_B) begin
                    take_a    = Req_A && (!Req_B || prio_a);
                    grant_a_n = take_a;
                    grant_b_n = !take_a;
                    prio_a_n  = !take_a;
                    busy_n    = 1'b1;
                    cnt_n     = '0;
                    j_n       = take_a ? calc_j(Op_A, Data_A, Mask_A) : calc_j(Op_B, Data_B, Mask_B);
                    k_n       = take_a ? calc_k(Op_A, Data_A, Mask_A) : calc_k(Op_B, Data_B, Mask_B);
                    state_n   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
                    strobe_n = 1'b0;
                    state_n  = ST_PULSE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_PULSE: begin
                ack_a_n = Grant_A;
                ack_b_n = Grant_B;
                state_n = ST_RELEASE;
            end
            ST_RELEASE: begin
                grant_a_n = 1'b0;
                grant_b_n = 1'b0;
                busy_n    = 1'b0;
                j_n       = '0;
                k_n       = '0;
                state_n   = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            prio_a     <= 1'b1;
            Grant_A    <= 1'b0;
            Grant_B    <= 1'b0;
            Ack_A      <= 1'b0;
            Ack_B      <= 1'b0;
            Busy       <= 1'b0;
            Strobe_bar <= 1'b1;
            J          <= '0;
            K          <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            prio_a     <= prio_a_n;
            Grant_A    <= grant_a_n;
            Grant_B    <= grant_b_n;
            Ack_A      <= ack_a_n;
            Ack_B      <= ack_b_n;
            Busy       <= busy_n;
            Strobe_bar <= strobe_n;
            J          <= j_n;
            K          <= k_n;
        end
    end

`ifdef JK_ARB_READBACK_EN
    logic [BLOCKS-1:0] q_snap;
    logic [BLOCKS-1:0] q_pred_c;

    // Expected bank state after the strobe, from the pre-strobe snapshot and the held J/K.
    assign q_pred_c = (J & K & ~q_snap) | (J & ~K) | (~J & ~K & q_snap);

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            q_snap   <= '0;
            Mismatch <= 1'b0;
        end else begin
            if (state == ST_SETUP) begin
                q_snap <= Q;
            end
            if (state == ST_RELEASE && Q != q_pred_c) begin
                Mismatch <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter with a behavioural negedge J-K bank on Strobe_bar.
module tb_jk_bank_arbiter;

    logic       clk = 1'b0;
    logic       clear_bar;
    logic       req_a, req_b;
    logic [1:0] op_a, op_b;
    logic [2:0] data_a, data_b, mask_a, mask_b;
    logic       grant_a, grant_b, ack_a, ack_b, busy, strobe_bar;
    logic [2:0] j, k;
    logic [2:0] bank_q = 3'b000;
    int         strobes = 0;
    int         checks = 0;
    int         errors = 0;

`ifdef JK_ARB_READBACK_EN
    logic       stuck = 1'b0;
    logic [2:0] q_in;
    logic       mismatch;
    assign q_in = stuck ? 3'b000 : bank_q;
`endif

    always #5 clk = ~clk;

    jk_bank_arbiter #(.BLOCKS(3), .SETUP_CYCLES(1)) dut (
        .Clk(clk), .Clear_bar(clear_bar),
        .Req_A(req_a), .Req_B(req_b), .Op_A(op_a), .Op_B(op_b),
        .Data_A(data_a), .Data_B(data_b), .Mask_A(mask_a), .Mask_B(mask_b),
        .Grant_A(grant_a), .Grant_B(grant_b), .Ack_A(ack_a), .Ack_B(ack_b),
        .Busy(busy), .J(j), .K(k), .Strobe_bar(strobe_bar)
`ifdef JK_ARB_READBACK_EN
        , .Q(q_in), .Mismatch(mismatch)
`endif
    );

    // Behavioural 7473-style bank: falling edge of its clock applies J/K per bit.
    always @(negedge strobe_bar) begin
        strobes++;
        for (int i = 0; i < 3; i++) begin
            case ({j[i], k[i]})
                2'b01:   bank_q[i] <= 1'b0;
                2'b10:   bank_q[i] <= 1'b1;
                2'b11:   bank_q[i] <= ~bank_q[i];
                default: bank_q[i] <= bank_q[i];
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_a = 0; req_b = 0; op_a = 2'b00; op_b = 2'b00;
        data_a = 3'b000; data_b = 3'b000; mask_a = 3'b000; mask_b = 3'b000;
    endtask

    task automatic test_reset;
        idle_inputs();
        clear_bar = 0; req_a = 1; op_a = 2'b10; mask_a = 3'b111;
        repeat (3) tick();
        checks++;
        if ({grant_a, grant_b, ack_a, ack_b, busy, strobe_bar} !== 6'b000001) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000001", {grant_a, grant_b, ack_a, ack_b, busy, strobe_bar});
        end
        checks++;
        if ({j, k} !== 6'b000000) begin
            errors++; $display("FAIL reset_jk: got %b expected 000000", {j, k});
        end
        checks++;
        if (strobes !== 0) begin
            errors++; $display("FAIL reset_no_strobe: got %0d expected 0", strobes);
        end
        req_a = 0;
        clear_bar = 1;
        repeat (2) tick();
        checks++;
        if ({grant_a, grant_b, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_idle: got %b expected 000", {grant_a, grant_b, busy});
        end
    endtask

    task automatic test_load;
        req_a = 1; op_a = 2'b01; data_a = 3'b101; mask_a = 3'b111;
        tick();
        checks++;
        if ({grant_a, grant_b, busy, strobe_bar, j, k} !== {4'b1011, 3'b101, 3'b010}) begin
            errors++; $display("FAIL load_setup: got %b expected 1011101010", {grant_a, grant_b, busy, strobe_bar, j, k});
        end
        req_a = 0; op_a = 2'b11; data_a = 3'b000;
        tick();
        checks++;
        if ({strobe_bar, j, k} !== {1'b0, 3'b101, 3'b010}) begin
            errors++; $display("FAIL load_pulse: got %b expected 0101010", {strobe_bar, j, k});
        end
        tick();
        checks++;
        if ({strobe_bar, ack_a, ack_b, grant_a} !== 4'b1101) begin
            errors++; $display("FAIL load_release: got %b expected 1101", {strobe_bar, ack_a, ack_b, grant_a});
        end
        tick();
        checks++;
        if ({ack_a, grant_a, busy, j, k} !== 9'b000000000) begin
            errors++; $display("FAIL load_idle: got %b expected 000000000", {ack_a, grant_a, busy, j, k});
        end
        checks++;
        if (bank_q !== 3'b101 || strobes !== 1) begin
            errors++; $display("FAIL load_bank: got q=%b strobes=%0d expected q=101 strobes=1", bank_q, strobes);
        end
    endtask

    task automatic test_toggle_clear;
        req_b = 1; op_b = 2'b10; mask_b = 3'b110; data_b = 3'b000;
        tick();
        checks++;
        if ({grant_a, grant_b, j, k} !== {2'b01, 3'b110, 3'b110}) begin
            errors++; $display("FAIL toggle_setup: got %b expected 01110110", {grant_a, grant_b, j, k});
        end
        req_b = 0;
        repeat (2) tick();
        checks++;
        if ({ack_a, ack_b} !== 2'b01) begin
            errors++; $display("FAIL toggle_ack: got %b expected 01", {ack_a, ack_b});
        end
        tick();
        checks++;
        if (bank_q !== 3'b011) begin
            errors++; $display("FAIL toggle_bank: got %b expected 011", bank_q);
        end
        req_b = 1; op_b = 2'b11; mask_b = 3'b111;
        tick();
        checks++;
        if ({j, k} !== {3'b000, 3'b111}) begin
            errors++; $display("FAIL clear_setup: got %b expected 000111", {j, k});
        end
        req_b = 0;
        repeat (3) tick();
        checks++;
        if (bank_q !== 3'b000) begin
            errors++; $display("FAIL clear_bank: got %b expected 000", bank_q);
        end
    endtask

    task automatic test_fairness;
        int n_grants, overlap, acks, bad_ack, s0;
        logic [3:0] order;
        logic prev_ga, prev_gb;
        n_grants = 0; overlap = 0; acks = 0; bad_ack = 0; order = 4'b0000;
        prev_ga = 0; prev_gb = 0;
        clear_bar = 0;
        req_a = 1; op_a = 2'b01; data_a = 3'b001; mask_a = 3'b111;
        req_b = 1; op_b = 2'b01; data_b = 3'b110; mask_b = 3'b111;
        tick();
        s0 = strobes;
        clear_bar = 1;
        repeat (16) begin
            tick();
            if (grant_a && grant_b) overlap++;
            if ((ack_a && !grant_a) || (ack_b && !grant_b)) bad_ack++;
            if (ack_a || ack_b) acks++;
            if ((grant_a && !prev_ga) || (grant_b && !prev_gb)) begin
                n_grants++;
                order = {order[2:0], grant_b};
            end
            prev_ga = grant_a; prev_gb = grant_b;
        end
        req_a = 0; req_b = 0;
        checks++;
        if (n_grants !== 4 || order !== 4'b0101) begin
            errors++; $display("FAIL fair_order: got n=%0d order=%b expected n=4 order=0101", n_grants, order);
        end
        checks++;
        if (overlap !== 0 || bad_ack !== 0) begin
            errors++; $display("FAIL fair_exclusive: got overlap=%0d bad_ack=%0d expected 0 0", overlap, bad_ack);
        end
        checks++;
        if (acks !== 4 || (strobes - s0) !== 4) begin
            errors++; $display("FAIL fair_counts: got acks=%0d strobes=%0d expected 4 4", acks, strobes - s0);
        end
        checks++;
        if (bank_q !== 3'b110) begin
            errors++; $display("FAIL fair_bank: got %b expected 110", bank_q);
        end
    endtask

    task automatic test_abort;
        int acks;
        acks = 0;
        req_a = 1; op_a = 2'b10; mask_a = 3'b111;
        tick();
        req_a = 0;
        tick();
        checks++;
        if ({strobe_bar, grant_a} !== 2'b01) begin
            errors++; $display("FAIL abort_pulse: got %b expected 01", {strobe_bar, grant_a});
        end
        clear_bar = 0;
        #1;
        checks++;
        if ({strobe_bar, grant_a, busy, j, k} !== {3'b100, 6'b000000}) begin
            errors++; $display("FAIL abort_reset: got %b expected 100000000", {strobe_bar, grant_a, busy, j, k});
        end
        repeat (2) begin
            tick();
            if (ack_a) acks++;
        end
        checks++;
        if (acks !== 0 || bank_q !== 3'b001) begin
            errors++; $display("FAIL abort_noack: got acks=%0d q=%b expected 0 001", acks, bank_q);
        end
        clear_bar = 1;
        req_b = 1; op_b = 2'b01; data_b = 3'b010; mask_b = 3'b111;
        tick();
        checks++;
        if ({grant_a, grant_b} !== 2'b01) begin
            errors++; $display("FAIL abort_regrant: got %b expected 01", {grant_a, grant_b});
        end
        req_b = 0;
        repeat (2) tick();
        checks++;
        if (ack_b !== 1'b1) begin
            errors++; $display("FAIL abort_ackb: got %b expected 1", ack_b);
        end
        tick();
        checks++;
        if (bank_q !== 3'b010) begin
            errors++; $display("FAIL abort_bank: got %b expected 010", bank_q);
        end
    endtask

`ifdef JK_ARB_READBACK_EN
    task automatic test_readback;
        checks++;
        if (mismatch !== 1'b0) begin
            errors++; $display("FAIL rb_clean: got %b expected 0", mismatch);
        end
        stuck = 1;
        req_a = 1; op_a = 2'b01; data_a = 3'b111; mask_a = 3'b111;
        tick();
        req_a = 0;
        repeat (3) tick();
        checks++;
        if (mismatch !== 1'b1) begin
            errors++; $display("FAIL rb_set: got %b expected 1", mismatch);
        end
        repeat (3) tick();
        checks++;
        if (mismatch !== 1'b1) begin
            errors++; $display("FAIL rb_sticky: got %b expected 1", mismatch);
        end
        stuck = 0;
        clear_bar = 0;
        #1;
        checks++;
        if (mismatch !== 1'b0) begin
            errors++; $display("FAIL rb_clear: got %b expected 0", mismatch);
        end
        clear_bar = 1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_toggle_clear();
        test_fairness();
        test_abort();
`ifdef JK_ARB_READBACK_EN
        test_readback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
